rx_uart: RTL and testbench

RX_UART -- requirements
Module: rx_uart

---
 rtl/rx_uart.sv | 159 +++++++++++++++
 tb/tb_rx_uart.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_uart.sv
// UART receiver: 16x oversampled 8N1 deserializer feeding a FIFO write port.
// Define RX_UART_MAJORITY_EN to vote each bit over samples 6, 7 and 8 instead of using sample 7 alone.
module rx_uart #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_COUNT = CLK_FREQ / (BAUD_RATE * 16)
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       rxData,
    input  logic       full,
    output logic [7:0] din,
    output logic       writeEn,
    output logic       frameErr,
    output logic       overrun,
    output logic       busy,
    output logic [2:0] dbgState
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);

    logic          rxMeta;
    logic          rxSync;
    logic [TW-1:0] tickCnt;
    logic          tick;
    logic [2:0]    state;
    logic [3:0]    sampleCnt;
    logic [3:0]    midCnt;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic          s7;
    logic          bitVal;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rxData;
            rxSync <= rxMeta;
        end
    end

    assign tick = (tickCnt == TICK_LAST);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) tickCnt <= '0;
        else if (tick) tickCnt <= '0;
        else tickCnt <= tickCnt + TW'(1);
    end

    // The decision tick is sample 8 in both builds so timing never depends on the vote mode;
    // samples 6 and 7 are captured on the two ticks before it.
    assign midCnt = (state == START) ? 4'd7 : 4'd15;

`ifdef RX_UART_MAJORITY_EN
    logic s6;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) s6 <= 1'b1;
        else if (tick && sampleCnt == midCnt - 4'd2) s6 <= rxSync;
    end

    assign bitVal = (s6 & s7) | (s6 & rxSync) | (s7 & rxSync);
`else
    assign bitVal = s7;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) s7 <= 1'b1;
        else if (tick && sampleCnt == midCnt - 4'd1) s7 <= rxSync;
    end

    // writeEn is a one-cycle strobe with no back-pressure: full is looked at only on the
    // stop-bit decision tick, and a byte that cannot be written is reported by overrun.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            sampleCnt <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            din       <= '0;
            writeEn   <= 1'b0;
            frameErr  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            writeEn  <= 1'b0;
            frameErr <= 1'b0;
            overrun  <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rxSync) begin
                            state     <= START;
                            sampleCnt <= '0;
                        end
                    end
                    START: begin
                        if (sampleCnt == 4'd7) begin
                            sampleCnt <= '0;
                            if (!bitVal) begin
                                state  <= DATA;
                                bitCnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (sampleCnt == 4'd15) begin
                            sampleCnt <= '0;
                            shiftReg  <= {bitVal, shiftReg[7:1]};
                            if (bitCnt == 3'd7) state <= STOP;
                            else bitCnt <= bitCnt + 3'd1;
                        end else begin
                            sampleCnt <= sampleCnt + 4'd1;
                        end
                    end
                    STOP: begin
                        if (sampleCnt == 4'd15) begin
                            sampleCnt <= '0;
                            if (bitVal) begin
                                state <= IDLE;
                                if (full) begin
                                    overrun <= 1'b1;
                                end else begin
                                    din     <= shiftReg;
                                    writeEn <= 1'b1;
                                end
                            end else begin
                                state    <= WAIT_IDLE;
                                frameErr <= 1'b1;
                            end
                        end else begin
                            sampleCnt <= sampleCnt + 4'd1;
                        end
                    end
                    WAIT_IDLE: begin
                        if (rxSync) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy     = (state != IDLE);
    assign dbgState = state;

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: serial frames driven bit by bit, received bytes checked
// against an expected queue, pulse counters checked per scenario.
module tb_rx_uart;

    localparam int TICK     = 8;
    localparam int BIT_CLKS = 16 * TICK;

    logic       clk;
    logic       rstN;
    logic       rxData;
    logic       full;
    logic [7:0] din;
    logic       writeEn;
    logic       frameErr;
    logic       overrun;
    logic       busy;
    logic [2:0] dbgState;

    int         tests_run;
    int         tests_failed;
    logic [7:0] exp_q[$];
    int         wr_count;
    int         err_count;
    int         ovr_count;
    logic       prev_we;
    logic [7:0] last_byte;

    // 50 MHz / (390625 * 16) = 8 clks per tick, 128 clks per bit
    rx_uart #(
        .BAUD_RATE(390625),
        .CLK_FREQ (50_000_000)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .rxData  (rxData),
        .full    (full),
        .din     (din),
        .writeEn (writeEn),
        .frameErr(frameErr),
        .overrun (overrun),
        .busy    (busy),
        .dbgState(dbgState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // scoreboard: every write is popped against the expected queue
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            if (writeEn) begin
                wr_count++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_write: din=%02h, expected no write", din);
                end else begin
                    logic [7:0] exp;
                    exp = exp_q.pop_front();
                    if (din !== exp) begin
                        tests_failed++;
                        $display("FAIL write_data: din=%02h, expected %02h", din, exp);
                    end
                end
                tests_run++;
                if (prev_we) begin
                    tests_failed++;
                    $display("FAIL we_width: writeEn high %0d cycles in a row, expected 1", 2);
                end
            end
            if (frameErr) err_count++;
            if (overrun) ovr_count++;
            if (writeEn || frameErr || overrun) begin
                tests_run++;
                if (int'(writeEn) + int'(frameErr) + int'(overrun) != 1) begin
                    tests_failed++;
                    $display("FAIL pulse_exclusive: we=%b fe=%b ov=%b, expected one-hot",
                             writeEn, frameErr, overrun);
                end
            end
        end
        prev_we = writeEn;
    end

    task automatic drive_bit(input logic v, input int clks);
        rxData = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CLKS);
        drive_bit(stop_bit, BIT_CLKS);
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
        last_byte = b;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle: busy=%b after %0d clks, expected 0", name, busy, budget);
        end
    endtask

    task automatic check_counts(input string name, input int wr0, input int err0, input int ovr0,
                                input int wr_exp, input int err_exp, input int ovr_exp);
        tests_run++;
        if (wr_count - wr0 != wr_exp) begin
            tests_failed++;
            $display("FAIL %s_writes: got %0d, expected %0d", name, wr_count - wr0, wr_exp);
        end
        tests_run++;
        if (err_count - err0 != err_exp) begin
            tests_failed++;
            $display("FAIL %s_frameerr: got %0d, expected %0d", name, err_count - err0, err_exp);
        end
        tests_run++;
        if (ovr_count - ovr0 != ovr_exp) begin
            tests_failed++;
            $display("FAIL %s_overrun: got %0d, expected %0d", name, ovr_count - ovr0, ovr_exp);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_queue: %0d bytes still expected, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rstN   = 1'b0;
        rxData = 1'b1;
        full   = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (din !== 8'h00) begin tests_failed++; $display("FAIL reset_din: got %02h, expected 00", din); end
        tests_run++;
        if (writeEn !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b, expected 0", writeEn); end
        tests_run++;
        if (frameErr !== 1'b0) begin tests_failed++; $display("FAIL reset_fe: got %b, expected 0", frameErr); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_ov: got %b, expected 0", overrun); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rstN = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL post_reset_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_basic();
        int wr0, err0, ovr0;
        wr0 = wr_count; err0 = err_count; ovr0 = ovr_count;
        push_exp(8'h55);
        send_frame(8'h55, 1'b1);
        wait_idle("basic", BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        check_counts("basic", wr0, err0, ovr0, 1, 0, 0);
        tests_run++;
        if (din !== 8'h55) begin tests_failed++; $display("FAIL basic_din: got %02h, expected 55", din); end
    endtask

    task automatic test_back_to_back();
        int wr0, err0, ovr0;
        wr0 = wr_count; err0 = err_count; ovr0 = ovr_count;
        push_exp(8'hA3);
        push_exp(8'h0F);
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_idle("b2b", BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        check_counts("b2b", wr0, err0, ovr0, 2, 0, 0);
        tests_run++;
        if (din !== 8'h0F) begin tests_failed++; $display("FAIL b2b_din: got %02h, expected 0F", din); end
    endtask

    task automatic test_frame_error();
        int wr0, err0, ovr0;
        wr0 = wr_count; err0 = err_count; ovr0 = ovr_count;
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 3 * BIT_CLKS);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL break_busy: got %b, expected 1", busy); end
        drive_bit(1'b1, 2 * BIT_CLKS);
        wait_idle("break", BIT_CLKS);
        check_counts("break", wr0, err0, ovr0, 0, 1, 0);
        wr0 = wr_count; err0 = err_count; ovr0 = ovr_count;
        push_exp(8'h81);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        check_counts("after_break", wr0, err0, ovr0, 1, 0, 0);
    endtask

    task automatic test_glitch();
        int wr0, err0, ovr0;
        wr0 = wr_count; err0 = err_count; ovr0 = ovr_count;
        drive_bit(1'b0, 4 * TICK);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_seen: busy=%b, expected 1", busy); end
        drive_bit(1'b1, 2 * BIT_CLKS);
        wait_idle("glitch", BIT_CLKS);
        check_counts("glitch", wr0, err0, ovr0, 0, 0, 0);
    endtask

    task automatic test_overrun();
        int wr0, err0, ovr0;
        wr0 = wr_count; err0 = err_count; ovr0 = ovr_count;
        full = 1'b1;
        send_frame(8'h7E, 1'b1);
        full = 1'b0;
        drive_bit(1'b1, BIT_CLKS);
        check_counts("overrun", wr0, err0, ovr0, 0, 0, 1);
        tests_run++;
        if (din !== last_byte) begin
            tests_failed++;
            $display("FAIL overrun_din: got %02h, expected %02h", din, last_byte);
        end
        // full high only while the data bits arrive must not block the write
        wr0 = wr_count; err0 = err_count; ovr0 = ovr_count;
        push_exp(8'h42);
        drive_bit(1'b0, BIT_CLKS);
        full = 1'b1;
        for (int i = 0; i < 8; i++) drive_bit(last_byte[i], BIT_CLKS);
        full = 1'b0;
        drive_bit(1'b1, 2 * BIT_CLKS);
        check_counts("full_early", wr0, err0, ovr0, 1, 0, 0);
    endtask

    task automatic test_reset_midframe();
        int wr0, err0, ovr0;
        logic [7:0] ff;
        ff = 8'hFF;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(ff[i], BIT_CLKS);
        rxData = 1'b1;
        rstN   = 1'b0;
        repeat (20) @(negedge clk);
        tests_run++;
        if (din !== 8'h00) begin tests_failed++; $display("FAIL midreset_din: got %02h, expected 00", din); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
        rstN = 1'b1;
        drive_bit(1'b1, 4 * BIT_CLKS);
        wr0 = wr_count; err0 = err_count; ovr0 = ovr_count;
        push_exp(8'h12);
        send_frame(8'h12, 1'b1);
        drive_bit(1'b1, BIT_CLKS);
        check_counts("midreset", wr0, err0, ovr0, 1, 0, 0);
        tests_run++;
        if (din !== 8'h12) begin tests_failed++; $display("FAIL midreset_next: got %02h, expected 12", din); end
    endtask

`ifdef RX_UART_MAJORITY_EN
    task automatic test_majority();
        int wr0, err0, ovr0;
        logic [7:0] b;
        b = 8'h5A;
        wr0 = wr_count; err0 = err_count; ovr0 = ovr_count;
        push_exp(b);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i], 7 * TICK);
            drive_bit(~b[i], TICK);
            drive_bit(b[i], 8 * TICK);
        end
        drive_bit(1'b1, 2 * BIT_CLKS);
        check_counts("majority", wr0, err0, ovr0, 1, 0, 0);
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        wr_count     = 0;
        err_count    = 0;
        ovr_count    = 0;
        prev_we      = 1'b0;
        last_byte    = 8'h00;
        rstN         = 1'b0;
        rxData       = 1'b1;
        full         = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_overrun();
        test_reset_midframe();
`ifdef RX_UART_MAJORITY_EN
        test_majority();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
